// File: rtl/cmp_pkg.sv
// Shared definitions for the shared-comparator arbiter: result encodings,
// slot state type and the round-robin pick function.
package cmp_pkg;

  localparam logic [2:0] CMP_GT = 3'b100;
  localparam logic [2:0] CMP_LT = 3'b010;
  localparam logic [2:0] CMP_EQ = 3'b001;

  localparam int unsigned MAX_REQ = 8;

  typedef enum logic {
    SLOT_EMPTY = 1'b0,
    SLOT_FULL  = 1'b1
  } slot_state_t;

  // First set bit of valid, searching from ptr upward and wrapping at nreq-1.
  // Returns 0 when nothing is valid; callers qualify with |valid.
  function automatic int unsigned rr_pick(input logic [MAX_REQ-1:0] valid,
                                          input int unsigned       ptr,
                                          input int unsigned       nreq);
    int unsigned       idx;
    logic              found;
    logic [MAX_REQ-1:0] sh;
    rr_pick = 0;
    found   = 1'b0;
    for (int unsigned k = 0; k < MAX_REQ; k++) begin
      if (k < nreq && !found) begin
        idx = ptr + k;
        if (idx >= nreq) idx = idx - nreq;
        sh = valid >> idx;
        if (sh[0]) begin
          rr_pick = idx;
          found   = 1'b1;
        end
      end
    end
  endfunction

endpackage

// File: rtl/cmp_share_arb_if.sv
// Request/response bundle between the client blocks and cmp_share_arb.
interface cmp_share_arb_if #(
  parameter int unsigned NREQ = 4,
  parameter int unsigned W    = 4,
  parameter int unsigned IDW  = 2
);
  logic [NREQ-1:0]   req_valid;
  logic [NREQ-1:0]   req_ready;
  logic [NREQ*W-1:0] req_a;
  logic [NREQ*W-1:0] req_b;
  logic              rsp_valid;
  logic              rsp_ready;
  logic [IDW-1:0]    rsp_id;
  logic              rsp_gt;
  logic              rsp_lt;
  logic              rsp_eq;
  logic [7:0]        done_cnt;

  modport master (
    output req_valid, req_a, req_b, rsp_ready,
    input  req_ready, rsp_valid, rsp_id, rsp_gt, rsp_lt, rsp_eq, done_cnt
  );

  modport slave (
    input  req_valid, req_a, req_b, rsp_ready,
    output req_ready, rsp_valid, rsp_id, rsp_gt, rsp_lt, rsp_eq, done_cnt
  );
endinterface

// File: rtl/mag_cmp.sv
// Combinational unsigned W-bit magnitude comparator: per-bit XNOR equality
// terms with MSB-first greater/less chains.
module mag_cmp #(
  parameter int unsigned W = 4
) (
  input  logic [W-1:0] a,
  input  logic [W-1:0] b,
  output logic         a_gt_b,
  output logic         a_lt_b,
  output logic         a_eq_b
);
  logic [W-1:0] eq_bit;

  assign eq_bit = ~(a ^ b);
  assign a_eq_b = &eq_bit;

  always_comb begin
    logic above_eq;
    a_gt_b   = 1'b0;
    a_lt_b   = 1'b0;
    above_eq = 1'b1;
    // A bit decides only when every more-significant bit matched.
    for (int unsigned k = 0; k < W; k++) begin
      a_gt_b   = a_gt_b | (above_eq & a[W-1-k] & ~b[W-1-k]);
      a_lt_b   = a_lt_b | (above_eq & ~a[W-1-k] & b[W-1-k]);
      above_eq = above_eq & eq_bit[W-1-k];
    end
  end
endmodule

// File: rtl/cmp_share_arb.sv
// Round-robin arbiter sharing one magnitude comparator among NREQ requesters;
// the winner's result lands in a single-entry registered response slot.
module cmp_share_arb
  import cmp_pkg::*;
#(
  parameter int unsigned NREQ = 4,
  parameter int unsigned W    = 4,
  parameter int unsigned IDW  = 2
) (
  input logic            clk,
  input logic            rst,
  cmp_share_arb_if.slave bus
);
  slot_state_t    state, state_nx;
  logic [IDW-1:0] rr_ptr, ptr_nx, pick, id_q;
  logic [2:0]     res_q, cmp_res;
  logic [7:0]     cnt_q;
  logic           any_req, slot_free, grant, drain;
  logic [W-1:0]   sel_a, sel_b;
  logic           c_gt, c_lt, c_eq;

  assign any_req   = |bus.req_valid;
  assign slot_free = (state == SLOT_EMPTY) || bus.rsp_ready;
  // Reset gates the grant so no requester sees ready while reset is held.
  assign grant     = ~rst & slot_free & any_req;
  assign drain     = (state == SLOT_FULL) & bus.rsp_ready;

  assign pick   = IDW'(rr_pick(MAX_REQ'(bus.req_valid), 32'(rr_ptr), NREQ));
  assign ptr_nx = (pick == IDW'(NREQ - 1)) ? '0 : pick + 1'b1;

  always_comb begin
    bus.req_ready = '0;
    for (int unsigned k = 0; k < NREQ; k++) begin
      bus.req_ready[k] = grant && (pick == IDW'(k));
    end
  end

  always_comb begin
    sel_a = '0;
    sel_b = '0;
    for (int unsigned k = 0; k < NREQ; k++) begin
      if (pick == IDW'(k)) begin
        sel_a = bus.req_a[k*W +: W];
        sel_b = bus.req_b[k*W +: W];
      end
    end
  end

  mag_cmp #(.W(W)) u_cmp (
    .a      (sel_a),
    .b      (sel_b),
    .a_gt_b (c_gt),
    .a_lt_b (c_lt),
    .a_eq_b (c_eq)
  );

  always_comb begin
    cmp_res = CMP_EQ;
    if (c_gt)      cmp_res = CMP_GT;
    else if (c_lt) cmp_res = CMP_LT;
    else if (c_eq) cmp_res = CMP_EQ;
  end

  always_comb begin
    state_nx = state;
    case (state)
      SLOT_EMPTY: if (grant)          state_nx = SLOT_FULL;
      SLOT_FULL:  if (drain && !grant) state_nx = SLOT_EMPTY;
      default:                        state_nx = SLOT_EMPTY;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state  <= SLOT_EMPTY;
      id_q   <= '0;
      res_q  <= '0;
      rr_ptr <= '0;
      cnt_q  <= '0;
    end else begin
      state <= state_nx;
      if (grant) begin
        id_q   <= pick;
        res_q  <= cmp_res;
        rr_ptr <= ptr_nx;
      end
      if (drain) cnt_q <= cnt_q + 8'd1;
    end
  end

  assign bus.rsp_valid = (state == SLOT_FULL);
  assign bus.rsp_id    = id_q;
  assign bus.rsp_gt    = res_q[2];
  assign bus.rsp_lt    = res_q[1];
  assign bus.rsp_eq    = res_q[0];
  assign bus.done_cnt  = cnt_q;
endmodule
